// File: rtl/relu_sched.sv
// relu_sched: round-robin arbiter sharing one 1-cycle ReLU core among N_CH streams, with a
// tagged, credit-guarded result FIFO. Define RELU_SCHED_STATS_EN to add stat_beats/stat_neg.
module relu_sched #(
   parameter int N_CH   = 4,
   parameter int BURST  = 8,
   parameter int FIFO_D = 4,
   localparam int CW    = $clog2(N_CH),
   localparam int AW    = $clog2(FIFO_D)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH-1:0]      req_valid,
   input  logic [32*N_CH-1:0]   req_data,
   output logic [N_CH-1:0]      req_ready,
   output logic [31:0]          core_data,
   output logic                 core_valid,
   output logic                 core_rst_n,
   input  logic [31:0]          core_result,
   input  logic                 core_res_valid,
   output logic [31:0]          out_data,
   output logic [CW-1:0]        out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef RELU_SCHED_STATS_EN
   ,
   output logic [15:0]          stat_beats,
   output logic [15:0]          stat_neg
`endif
);

   // state | meaning
   // IDLE  | no grant; pick first requester at/after rr_ptr once a credit exists
   // GRANT | gnt owns the core until BURST beats or it drops valid with a credit available
   typedef enum logic [0:0] {IDLE, GRANT} state_t;

   localparam int              CW1        = CW + 1;
   localparam int              AW1        = AW + 1;
   localparam logic [CW-1:0]   LAST_CH    = CW'(N_CH - 1);
   localparam logic [CW:0]     N_CH_W     = CW1'(N_CH);
   localparam logic [7:0]      BURST_LAST = 8'(BURST - 1);
   localparam logic [AW:0]     DEPTH_W    = AW1'(FIFO_D);

   state_t          state, state_nxt;
   logic [CW-1:0]   gnt, gnt_nxt, gnt_inc;
   logic [CW-1:0]   rr_ptr, rr_nxt;
   logic [7:0]      beat_cnt, beat_nxt;
   logic [2*N_CH-1:0] rv2;
   logic [N_CH-1:0] rv_rot;
   logic [CW-1:0]   pick_off, pick;
   logic [CW:0]     pick_sum;
   logic            pick_any;
   logic            credit, xfer;

   logic            tag_vld, tag_err;
   logic [CW-1:0]   tag;

   logic [CW+31:0]  mem [FIFO_D];
   logic [AW:0]     wr_ptr, rd_ptr, occ;
   logic [CW+31:0]  head;
   logic            push, pop;

   assign core_rst_n = ~rst;

   // Rotate the valid vector so bit 0 is rr_ptr; the lowest set bit is the next winner.
   assign rv2    = {req_valid, req_valid};
   assign rv_rot = N_CH'(rv2 >> rr_ptr);

   always_comb begin
      pick_off = '0;
      pick_any = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (rv_rot[k]) begin
            pick_off = CW'(k);
            pick_any = 1'b1;
         end
      end
   end

   assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
   assign pick     = (pick_sum >= N_CH_W) ? CW'(pick_sum - N_CH_W) : pick_sum[CW-1:0];
   assign gnt_inc  = (gnt == LAST_CH) ? '0 : gnt + CW'(1);

   // Credits come from registered state only, so a pop frees a slot for the next cycle.
   assign occ    = wr_ptr - rd_ptr;
   assign credit = (occ + AW1'(tag_vld)) < DEPTH_W;

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      rr_nxt    = rr_ptr;
      beat_nxt  = beat_cnt;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any && credit) begin
               gnt_nxt   = pick;
               beat_nxt  = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (credit) begin
               if (req_valid[gnt]) begin
                  xfer     = 1'b1;
                  beat_nxt = beat_cnt + 8'd1;
                  if (beat_cnt == BURST_LAST) begin
                     state_nxt = IDLE;
                     rr_nxt    = gnt_inc;
                  end
               end else begin
                  state_nxt = IDLE;
                  rr_nxt    = gnt_inc;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         rr_ptr   <= rr_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[gnt] = 1'b1;
   end

   assign core_valid = xfer;
   assign core_data  = xfer ? req_data[{gnt, 5'd0} +: 32] : '0;

   // One tag slot suffices because the core result always lands exactly one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= 1'b0;
         tag     <= '0;
         tag_err <= 1'b0;
      end else begin
         tag_vld <= xfer;
         if (xfer) tag <= gnt;
         if (core_res_valid && !tag_vld) tag_err <= 1'b1;
      end
   end

   tag_err_never: assert property (@(posedge clk) disable iff (rst) !tag_err);

   assign push = core_res_valid & tag_vld;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW1'(1);
         if (pop)  rd_ptr <= rd_ptr + AW1'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {tag, core_result};
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign out_valid = (wr_ptr != rd_ptr);
   assign out_data  = out_valid ? head[31:0] : '0;
   assign out_ch    = out_valid ? head[CW+31:32] : '0;

`ifdef RELU_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_beats <= '0;
         stat_neg   <= '0;
      end else begin
         if (pop && stat_beats != 16'hFFFF) stat_beats <= stat_beats + 16'd1;
         if (xfer && core_data[31] && stat_neg != 16'hFFFF) stat_neg <= stat_neg + 16'd1;
      end
   end
`endif

endmodule
